// File: rtl/simple_serial_multi.sv
// Serial master with multiple chip selects, programmable sclk rate and bit order.
// Single-word transfers started by a trigger pulse; status, overrun and count outputs.
module simple_serial_multi #(
   parameter int DATA_W = 32,
   parameter int N_CS   = 4,
   parameter int DIV_W  = 8,
   localparam int LEN_W = $clog2(DATA_W + 1),
   localparam int CS_W  = (N_CS > 1) ? $clog2(N_CS) : 1
) (
   input  logic              axi_clk,
   input  logic              axi_resetn,
   input  logic [DATA_W-1:0] write_data,
   input  logic [LEN_W-1:0]  data_len,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic              lsb_first,
   input  logic              trigger,
   input  logic              poci,
   output logic [DATA_W-1:0] read_data,
   output logic [2:0]        status,
   output logic              overrun,
   output logic [31:0]       transaction_count,
   output logic              done,
   output logic              sclk,
   output logic              pico,
   output logic [N_CS-1:0]   cs_b
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [2:0] ST_IDLE = 3'b000;
   localparam logic [2:0] ST_BUSY = 3'b001;
   localparam logic [2:0] ST_DONE = 3'b010;
   localparam logic [2:0] ST_ERR  = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_rst_sync;
   logic              w_rst_n;
   logic [DATA_W-1:0] r_data;
   logic [LEN_W-1:0]  r_len;
   logic [DIV_W-1:0]  r_div;
   logic              r_lsb;
   logic [DIV_W-1:0]  r_cnt;
   logic [LEN_W-1:0]  r_bit;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_read_data;
   logic [2:0]        r_status;
   logic              r_overrun;
   logic [31:0]       r_count;
   logic              r_done;
   logic              r_sclk;
   logic              r_pico;
   logic [N_CS-1:0]   r_cs_b;
   logic [N_CS-1:0]   w_cs_dec;
   logic              w_args_ok;
   logic              w_tick;
   logic              w_last;
   logic [IDX_W-1:0]  w_rx_idx;
   logic [IDX_W-1:0]  w_first_idx;
   logic [IDX_W-1:0]  w_next_idx;

   // Bit position of the k-th transferred bit for the given order and length.
   function automatic logic [IDX_W-1:0] f_idx(
      input logic [LEN_W-1:0] k,
      input logic [LEN_W-1:0] len,
      input logic             lsb
   );
      logic [LEN_W-1:0] v;
      v = lsb ? k : (len - LEN_W'(1) - k);
      return v[IDX_W-1:0];
   endfunction

   assign w_rst_n     = r_rst_sync[1];
   assign w_args_ok   = (data_len != '0)
                     && (int'(data_len) <= DATA_W)
                     && (int'(cs_sel) < N_CS);
   assign w_tick      = (r_cnt == r_div);
   assign w_last      = (r_bit == r_len - LEN_W'(1));
   assign w_rx_idx    = f_idx(r_bit, r_len, r_lsb);
   assign w_first_idx = f_idx('0, data_len, lsb_first);
   assign w_next_idx  = f_idx(r_bit + LEN_W'(1), r_len, r_lsb);

   // Active-low select pattern for the requested target.
   always_comb begin
      w_cs_dec = '1;
      for (int i = 0; i < N_CS; i++) begin
         if (int'(cs_sel) == i) w_cs_dec[i] = 1'b0;
      end
   end

   // Reset asserts asynchronously, releases on a clock edge.
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) r_rst_sync <= 2'b00;
      else             r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   // State register.
   always_ff @(posedge axi_clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic: each non-idle state lasts clk_div+1 cycles.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (trigger && w_args_ok) w_next = S_SETUP;
         S_SETUP: if (w_tick) w_next = S_HIGH;
         S_HIGH:  if (w_tick) w_next = w_last ? S_HOLD : S_LOW;
         S_LOW:   if (w_tick) w_next = S_HIGH;
         S_HOLD:  if (w_tick) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: capture, shifting, sampling and completion bookkeeping.
   always_ff @(posedge axi_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_data      <= '0;
         r_len       <= '0;
         r_div       <= '0;
         r_lsb       <= 1'b0;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_rx        <= '0;
         r_read_data <= '0;
         r_status    <= ST_IDLE;
         r_overrun   <= 1'b0;
         r_count     <= '0;
         r_done      <= 1'b0;
         r_sclk      <= 1'b0;
         r_pico      <= 1'b0;
         r_cs_b      <= '1;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE || w_tick) r_cnt <= '0;
         else                             r_cnt <= r_cnt + DIV_W'(1);
         if (trigger) begin
            if (r_state != S_IDLE) begin
               r_overrun <= 1'b1;
            end else begin
               r_overrun <= 1'b0;
               if (!w_args_ok) begin
                  r_status <= ST_ERR;
               end else begin
                  r_data   <= write_data;
                  r_len    <= data_len;
                  r_div    <= clk_div;
                  r_lsb    <= lsb_first;
                  r_bit    <= '0;
                  r_rx     <= '0;
                  r_status <= ST_BUSY;
                  r_cs_b   <= w_cs_dec;
                  r_sclk   <= 1'b0;
                  r_pico   <= write_data[w_first_idx];
               end
            end
         end
         if (r_state == S_HIGH && r_cnt == '0) r_rx[w_rx_idx] <= poci;
         if (w_tick) begin
            unique case (r_state)
               S_SETUP, S_LOW: r_sclk <= 1'b1;
               S_HIGH: begin
                  r_sclk <= 1'b0;
                  if (!w_last) begin
                     r_bit  <= r_bit + LEN_W'(1);
                     r_pico <= r_data[w_next_idx];
                  end
               end
               S_HOLD: begin
                  r_cs_b      <= '1;
                  r_done      <= 1'b1;
                  r_status    <= ST_DONE;
                  r_count     <= r_count + 32'd1;
                  r_read_data <= r_rx;
               end
               default: ;
            endcase
         end
      end
   end

   assign read_data         = r_read_data;
   assign status            = r_status;
   assign overrun           = r_overrun;
   assign transaction_count = r_count;
   assign done              = r_done;
   assign sclk              = r_sclk;
   assign pico              = r_pico;
   assign cs_b              = r_cs_b;

endmodule

// File: tb/tb_simple_serial_multi.sv
// Directed bench for simple_serial_multi: vector table plus corner sequences.
// Built with three selects so an out-of-range select index is representable.
module tb_simple_serial_multi;

   logic        axi_clk;
   logic        axi_resetn;
   logic [31:0] write_data;
   logic [5:0]  data_len;
   logic [1:0]  cs_sel;
   logic [7:0]  clk_div;
   logic        lsb_first;
   logic        trigger;
   logic        poci;
   logic [31:0] read_data;
   logic [2:0]  status;
   logic        overrun;
   logic [31:0] transaction_count;
   logic        done;
   logic        sclk;
   logic        pico;
   logic [2:0]  cs_b;
   logic [1:0]  poci_mode;

   int          n_chk;
   int          n_fail;
   logic [31:0] exp_count;

   typedef struct {
      logic [5:0]  len;
      logic [31:0] data;
      logic        lsb;
      logic [7:0]  div;
      logic [1:0]  cs;
      logic [1:0]  pmode;
      logic [31:0] exp_rd;
      logic [31:0] exp_pseq;
      int          exp_csb;
   } vec_t;

   vec_t vecs[6];

   simple_serial_multi #(
      .DATA_W(32),
      .N_CS(3),
      .DIV_W(8)
   ) dut (
      .axi_clk(axi_clk),
      .axi_resetn(axi_resetn),
      .write_data(write_data),
      .data_len(data_len),
      .cs_sel(cs_sel),
      .clk_div(clk_div),
      .lsb_first(lsb_first),
      .trigger(trigger),
      .poci(poci),
      .read_data(read_data),
      .status(status),
      .overrun(overrun),
      .transaction_count(transaction_count),
      .done(done),
      .sclk(sclk),
      .pico(pico),
      .cs_b(cs_b)
   );

   // 0 = loopback, 1 = tied high, 2 = tied low
   assign poci = (poci_mode == 2'd0) ? pico : poci_mode[0];

   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic start(input logic [5:0] len, input logic [31:0] d,
                        input logic lsb, input logic [7:0] div,
                        input logic [1:0] cs);
      @(posedge axi_clk); #1;
      data_len   = len;
      write_data = d;
      lsb_first  = lsb;
      clk_div    = div;
      cs_sel     = cs;
      trigger    = 1'b1;
      @(posedge axi_clk); #1;
      trigger    = 1'b0;
      write_data = ~d;
      data_len   = 6'd1;
      clk_div    = 8'd7;
      lsb_first  = ~lsb;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(posedge axi_clk); #1;
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int          csb_n;
      int          bits;
      int          hi_run;
      int          budget;
      bit          first_hi_done;
      bit          bad_cs;
      bit          seen_done;
      logic        prev_sclk;
      logic [31:0] seq;
      csb_n = 0;
      bits = 0;
      hi_run = 0;
      first_hi_done = 1'b0;
      bad_cs = 1'b0;
      seen_done = 1'b0;
      prev_sclk = 1'b0;
      seq = '0;
      budget = (2 * int'(v.len) + 1) * (int'(v.div) + 1) + 8;
      poci_mode = v.pmode;
      start(v.len, v.data, v.lsb, v.div, v.cs);
      chk({nm, "_busy"}, {29'd0, status}, 32'd1);
      for (int c = 0; c < budget && !seen_done; c++) begin
         if (c > 0) begin
            @(posedge axi_clk); #1;
         end
         if (cs_b[v.cs] == 1'b0) csb_n++;
         if ($countones(~cs_b) > 1) bad_cs = 1'b1;
         if (cs_b != 3'b111 && cs_b[v.cs]) bad_cs = 1'b1;
         if (sclk && !prev_sclk && bits < 32) begin
            seq[bits] = pico;
            bits++;
         end
         if (!sclk && prev_sclk) first_hi_done = 1'b1;
         if (sclk && !first_hi_done) hi_run++;
         prev_sclk = sclk;
         if (done) seen_done = 1'b1;
      end
      exp_count = exp_count + 32'd1;
      chk({nm, "_done_seen"}, {31'd0, seen_done}, 32'd1);
      chk({nm, "_csb_cycles"}, csb_n, v.exp_csb);
      chk({nm, "_one_cs"}, {31'd0, bad_cs}, 32'd0);
      chk({nm, "_pico_seq"}, seq, v.exp_pseq);
      chk({nm, "_nbits"}, bits, {26'd0, v.len});
      chk({nm, "_half"}, hi_run, int'(v.div) + 1);
      chk({nm, "_rdata"}, read_data, v.exp_rd);
      chk({nm, "_count"}, transaction_count, exp_count);
      chk({nm, "_status"}, {29'd0, status}, 32'd2);
      chk({nm, "_csb_idle"}, {29'd0, cs_b}, 32'd7);
      @(posedge axi_clk); #1;
      chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [5:0] e_len[3];
      logic [1:0] e_cs[3];
      bit         ok;
      bit         act;
      logic [31:0] rd_before;

      n_chk = 0;
      n_fail = 0;
      exp_count = '0;
      poci_mode = 2'd0;
      write_data = '0;
      data_len = '0;
      cs_sel = '0;
      clk_div = '0;
      lsb_first = 1'b0;
      trigger = 1'b0;

      vecs[0] = '{6'd8,  32'h000000A5, 1'b0, 8'd0, 2'd2, 2'd0,
                  32'h000000A5, 32'h000000A5, 17};
      vecs[1] = '{6'd4,  32'h00000003, 1'b1, 8'd3, 2'd0, 2'd1,
                  32'h0000000F, 32'h00000003, 36};
      vecs[2] = '{6'd1,  32'h00000001, 1'b0, 8'd1, 2'd1, 2'd2,
                  32'h00000000, 32'h00000001, 6};
      vecs[3] = '{6'd32, 32'h80000001, 1'b0, 8'd0, 2'd0, 2'd0,
                  32'h80000001, 32'h80000001, 65};
      vecs[4] = '{6'd12, 32'h0000F0F3, 1'b1, 8'd2, 2'd2, 2'd0,
                  32'h000000F3, 32'h000000F3, 75};
      vecs[5] = '{6'd5,  32'h00000016, 1'b0, 8'd0, 2'd1, 2'd1,
                  32'h0000001F, 32'h0000000D, 11};

      axi_resetn = 1'b1;
      #2 axi_resetn = 1'b0;
      repeat (3) @(posedge axi_clk);
      #1;
      chk("rst_csb", {29'd0, cs_b}, 32'd7);
      chk("rst_sclk_pico", {30'd0, sclk, pico}, 32'd0);
      chk("rst_done_ovr", {30'd0, done, overrun}, 32'd0);
      chk("rst_status", {29'd0, status}, 32'd0);
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_count", transaction_count, 32'd0);
      axi_resetn = 1'b1;
      repeat (4) @(posedge axi_clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      e_len[0] = 6'd0;  e_cs[0] = 2'd0;
      e_len[1] = 6'd33; e_cs[1] = 2'd0;
      e_len[2] = 6'd8;  e_cs[2] = 2'd3;
      for (int i = 0; i < 3; i++) begin
         rd_before = read_data;
         act = 1'b0;
         start(e_len[i], 32'h5A5A5A5A, 1'b0, 8'd0, e_cs[i]);
         for (int c = 0; c < 12; c++) begin
            if (cs_b != 3'b111 || sclk) act = 1'b1;
            @(posedge axi_clk); #1;
         end
         chk($sformatf("err%0d_status", i), {29'd0, status}, 32'd4);
         chk($sformatf("err%0d_activity", i), {31'd0, act}, 32'd0);
         chk($sformatf("err%0d_count", i), transaction_count, exp_count);
         chk($sformatf("err%0d_rdata", i), read_data, rd_before);
      end

      poci_mode = 2'd0;
      start(6'd8, 32'h0000003C, 1'b0, 8'd0, 2'd1);
      repeat (4) @(posedge axi_clk);
      #1 trigger = 1'b1;
      @(posedge axi_clk);
      #1 trigger = 1'b0;
      chk("ovr_mid_set", {31'd0, overrun}, 32'd1);
      wait_done(60, ok);
      exp_count = exp_count + 32'd1;
      chk("ovr_mid_done", {31'd0, ok}, 32'd1);
      chk("ovr_mid_rdata", read_data, 32'h0000003C);
      chk("ovr_mid_count", transaction_count, exp_count);

      start(6'd8, 32'h00000081, 1'b1, 8'd0, 2'd0);
      chk("ovr_clear_valid", {31'd0, overrun}, 32'd0);
      repeat (16) @(posedge axi_clk);
      #1 trigger = 1'b1;
      @(posedge axi_clk);
      #1 trigger = 1'b0;
      exp_count = exp_count + 32'd1;
      chk("hold_exit_done", {31'd0, done}, 32'd1);
      chk("hold_exit_ovr", {31'd0, overrun}, 32'd1);
      chk("hold_exit_csb", {29'd0, cs_b}, 32'd7);
      chk("hold_exit_status", {29'd0, status}, 32'd2);
      chk("hold_exit_rdata", read_data, 32'h00000081);
      chk("hold_exit_count", transaction_count, exp_count);
      start(6'd0, 32'h0, 1'b0, 8'd0, 2'd0);
      chk("ovr_clear_err", {31'd0, overrun}, 32'd0);
      chk("ovr_clear_err_st", {29'd0, status}, 32'd4);

      @(posedge axi_clk);
      #1 force dut.r_count = 32'hFFFFFFFF;
      #1 release dut.r_count;
      exp_count = 32'hFFFFFFFF;
      chk("wrap_preload", transaction_count, exp_count);
      run_vec(vecs[0], "wrap");

      poci_mode = 2'd0;
      start(6'd16, 32'h0000BEEF, 1'b0, 8'd0, 2'd0);
      repeat (6) @(posedge axi_clk);
      #2 axi_resetn = 1'b0;
      #1;
      chk("arst_csb", {29'd0, cs_b}, 32'd7);
      chk("arst_status", {29'd0, status}, 32'd0);
      chk("arst_sclk", {31'd0, sclk}, 32'd0);
      repeat (3) @(posedge axi_clk);
      #1 axi_resetn = 1'b1;
      act = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (done) act = 1'b1;
         @(posedge axi_clk); #1;
      end
      chk("arst_no_done", {31'd0, act}, 32'd0);
      chk("arst_count", transaction_count, 32'd0);
      chk("arst_rdata", read_data, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
